// File: rtl/complex_magnitude.sv
// Streaming floor(|re + j*im|): one-cycle squaring stage, then a bit-serial restoring square root.
// Optional peak tracker (largest magnitude and its output index) is enabled by PEAK_TRACK_EN.
module complex_magnitude #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned INDEX_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   resetN,
    input  logic                   enable,
    input  logic                   inValid,
    output logic                   inReady,
    input  logic [DATA_WIDTH-1:0]  inRe,
    input  logic [DATA_WIDTH-1:0]  inIm,
    output logic                   outValid,
    input  logic                   outReady,
    output logic [DATA_WIDTH-1:0]  absOut,
`ifdef PEAK_TRACK_EN
    input  logic                   clearPeak,
    output logic [DATA_WIDTH-1:0]  peakOut,
    output logic [INDEX_WIDTH-1:0] peakIndex,
`endif
    output logic                   busy
);

    localparam int unsigned DW = DATA_WIDTH;
    localparam int unsigned SW = 2 * DW;
    localparam int unsigned RW = DW + 2;
    localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {StIdle, StSquare, StRoot, StDone} state_e;

    state_e          state_q, state_d;
    logic [DW-1:0]   re_q, re_d, im_q, im_d;
    logic [SW-1:0]   rad_q, rad_d;
    logic [RW-1:0]   rem_q, rem_d;
    logic [DW-1:0]   root_q, root_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   abs_q, abs_d;
    logic            valid_q, valid_d;

    // Squares are formed at full 2*DW width so (-2^(DW-1))^2 is exact.
    logic signed [SW-1:0] re_ext, im_ext, re_sq, im_sq;
    logic [SW-1:0]        sum_sq;

    assign re_ext = SW'($signed(re_q));
    assign im_ext = SW'($signed(im_q));
    assign re_sq  = re_ext * re_ext;
    assign im_sq  = im_ext * im_ext;
    assign sum_sq = $unsigned(re_sq) + $unsigned(im_sq);

    // One restoring step: bring down two radicand bits, try subtracting 4*root + 1.
    logic [RW+1:0] cand, trial;
    logic          take;
    logic [RW-1:0] rem_sub, rem_nxt;
    logic [DW-1:0] root_nxt;

    assign cand     = {rem_q, rad_q[SW-1 -: 2]};
    assign trial    = {2'b00, root_q, 2'b01};
    assign take     = (cand >= trial);
    assign rem_sub  = cand[RW-1:0] - trial[RW-1:0];
    assign rem_nxt  = take ? rem_sub : cand[RW-1:0];
    assign root_nxt = {root_q[DW-2:0], take};

    always_comb begin
        state_d = state_q;
        re_d    = re_q;
        im_d    = im_q;
        rad_d   = rad_q;
        rem_d   = rem_q;
        root_d  = root_q;
        cnt_d   = cnt_q;
        abs_d   = abs_q;
        valid_d = valid_q;
        if (enable) begin
            unique case (state_q)
                StIdle: begin
                    if (inValid) begin
                        re_d    = inRe;
                        im_d    = inIm;
                        state_d = StSquare;
                    end
                end
                StSquare: begin
                    rad_d   = sum_sq;
                    rem_d   = '0;
                    root_d  = '0;
                    cnt_d   = CW'(DW - 1);
                    state_d = StRoot;
                end
                StRoot: begin
                    rad_d  = rad_q << 2;
                    rem_d  = rem_nxt;
                    root_d = root_nxt;
                    cnt_d  = cnt_q - CW'(1);
                    if (cnt_q == '0) begin
                        abs_d   = root_nxt;
                        valid_d = 1'b1;
                        state_d = StDone;
                    end
                end
                StDone: begin
                    if (outReady) begin
                        valid_d = 1'b0;
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            state_q <= StIdle;
            re_q    <= '0;
            im_q    <= '0;
            rad_q   <= '0;
            rem_q   <= '0;
            root_q  <= '0;
            cnt_q   <= '0;
            abs_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            re_q    <= re_d;
            im_q    <= im_d;
            rad_q   <= rad_d;
            rem_q   <= rem_d;
            root_q  <= root_d;
            cnt_q   <= cnt_d;
            abs_q   <= abs_d;
            valid_q <= valid_d;
        end
    end

    assign inReady  = resetN & enable & (state_q == StIdle);
    assign busy     = (state_q != StIdle);
    assign outValid = valid_q;
    assign absOut   = abs_q;

`ifdef PEAK_TRACK_EN
    logic                   hs;
    logic [DW-1:0]          peak_q, peak_d;
    logic [INDEX_WIDTH-1:0] pidx_q, pidx_d;
    logic [INDEX_WIDTH-1:0] ocnt_q, ocnt_d;

    assign hs = enable & (state_q == StDone) & outReady;

    always_comb begin
        peak_d = peak_q;
        pidx_d = pidx_q;
        ocnt_d = ocnt_q;
        if (enable && clearPeak) begin
            // A coincident result becomes output 0 of the fresh tracking window.
            peak_d = hs ? abs_q : '0;
            pidx_d = '0;
            ocnt_d = hs ? INDEX_WIDTH'(1) : '0;
        end else if (hs) begin
            if (abs_q > peak_q) begin
                peak_d = abs_q;
                pidx_d = ocnt_q;
            end
            ocnt_d = ocnt_q + INDEX_WIDTH'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            peak_q <= '0;
            pidx_q <= '0;
            ocnt_q <= '0;
        end else begin
            peak_q <= peak_d;
            pidx_q <= pidx_d;
            ocnt_q <= ocnt_d;
        end
    end

    assign peakOut   = peak_q;
    assign peakIndex = pidx_q;
`endif

endmodule
